// File: rtl/booth_mul_ctrl.sv
// Sequential 32x32->64 radix-4 Booth multiplier controller. It accumulates two Booth
// partial products per cycle in carry-save form through reducer_64.
// Optional macro BOOTH_UNSIGNED_EN adds in_unsigned and a ninth iteration for unsigned operands.

module reducer_64 (
    input  logic [63:0] in_w,
    input  logic [63:0] in_x,
    input  logic [63:0] in_y,
    input  logic [63:0] in_z,
    input  logic        in_cin,
    output logic [63:0] out_sum,
    output logic [63:0] out_carry,
    output logic        out_cout
);
    logic [63:0] s1_s;
    logic [63:0] c1_s;
    logic [63:0] cin2_s;
    logic [63:0] c2_s;

    // Two cascaded 3:2 stages; the first-stage carries ripple into the second stage one bit up.
    assign s1_s      = in_w ^ in_x ^ in_y;
    assign c1_s      = (in_w & in_x) | (in_w & in_y) | (in_x & in_y);
    assign cin2_s    = {c1_s[62:0], in_cin};
    assign out_sum   = s1_s ^ in_z ^ cin2_s;
    assign c2_s      = (s1_s & in_z) | (s1_s & cin2_s) | (in_z & cin2_s);
    assign out_carry = {c2_s[62:0], 1'b0};
    assign out_cout  = c1_s[63] ^ c2_s[63];
endmodule

module booth_mul_ctrl (
    input  logic        in_clk,
    input  logic        in_rst_n,
    input  logic        in_start,
    input  logic [31:0] in_multiplicand,
    input  logic [31:0] in_multiplier,
`ifdef BOOTH_UNSIGNED_EN
    input  logic        in_unsigned,
`endif
    output logic        out_busy,
    output logic        out_done,
    output logic [63:0] out_product
);
`ifdef BOOTH_UNSIGNED_EN
    localparam int QW = 37;
`else
    localparam int QW = 33;
`endif

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ITER = 2'd1, S_ADD = 2'd2} state_t;

    state_t          state_r;
    logic [63:0]     m_r;
    logic [QW-1:0]   q_r;
    logic [63:0]     sum_r;
    logic [63:0]     carry_r;
    logic [3:0]      k_r;
    logic [3:0]      last_k_s;
    logic [5:0]      shift_s;
    logic [63:0]     pp0_s;
    logic [63:0]     pp1_s;
    logic [63:0]     red_sum_s;
    logic [63:0]     red_carry_s;

    function automatic logic [63:0] booth_pp(input logic [2:0] win, input logic [63:0] m);
        logic [63:0] pp;
        case (win)
            3'b001, 3'b010: pp = m;
            3'b011:         pp = m << 1;
            3'b100:         pp = 64'd0 - (m << 1);
            3'b101, 3'b110: pp = 64'd0 - m;
            default:        pp = 64'd0;
        endcase
        return pp;
    endfunction

`ifdef BOOTH_UNSIGNED_EN
    logic       ext_m_s;
    logic       ext_q_s;
    logic [3:0] last_k_r;

    assign ext_m_s  = in_multiplicand[31] & ~in_unsigned;
    assign ext_q_s  = in_multiplier[31] & ~in_unsigned;
    assign last_k_s = last_k_r;
`else
    assign last_k_s = 4'd7;
`endif

    assign shift_s = {k_r, 2'b00};
    assign pp0_s   = booth_pp(q_r[2:0], m_r) << shift_s;
    assign pp1_s   = booth_pp(q_r[4:2], m_r) << (shift_s + 6'd2);

    reducer_64 u_reducer (
        .in_w      (sum_r),
        .in_x      (carry_r),
        .in_y      (pp0_s),
        .in_z      (pp1_s),
        .in_cin    (1'b0),
        .out_sum   (red_sum_s),
        .out_carry (red_carry_s),
        .out_cout  ()
    );

    // Control FSM with registered handshake outputs and the carry-save datapath state.
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_r     <= S_IDLE;
            m_r         <= 64'd0;
            q_r         <= '0;
            sum_r       <= 64'd0;
            carry_r     <= 64'd0;
            k_r         <= 4'd0;
            out_busy    <= 1'b0;
            out_done    <= 1'b0;
            out_product <= 64'd0;
`ifdef BOOTH_UNSIGNED_EN
            last_k_r    <= 4'd7;
`endif
        end else begin
            out_done <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (in_start) begin
`ifdef BOOTH_UNSIGNED_EN
                        m_r      <= {{32{ext_m_s}}, in_multiplicand};
                        q_r      <= {{4{ext_q_s}}, in_multiplier, 1'b0};
                        last_k_r <= in_unsigned ? 4'd8 : 4'd7;
`else
                        m_r      <= {{32{in_multiplicand[31]}}, in_multiplicand};
                        q_r      <= {in_multiplier, 1'b0};
`endif
                        sum_r    <= 64'd0;
                        carry_r  <= 64'd0;
                        k_r      <= 4'd0;
                        out_busy <= 1'b1;
                        state_r  <= S_ITER;
                    end else begin
                        state_r  <= S_IDLE;
                    end
                end
                S_ITER: begin
                    sum_r   <= red_sum_s;
                    carry_r <= red_carry_s;
                    q_r     <= {{4{q_r[QW-1]}}, q_r[QW-1:4]};
                    k_r     <= k_r + 4'd1;
                    if (k_r == last_k_s) begin
                        state_r <= S_ADD;
                    end else begin
                        state_r <= S_ITER;
                    end
                end
                S_ADD: begin
                    out_product <= sum_r + carry_r;
                    out_done    <= 1'b1;
                    out_busy    <= 1'b0;
                    state_r     <= S_IDLE;
                end
                default: begin
                    out_busy <= 1'b0;
                    state_r  <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/booth_mul_ctrl.md
# booth_mul_ctrl

Sequential 32x32 -> 64-bit radix-4 Booth multiplier controller for the Mini-SRC ALU. It owns one `reducer_64` instance and uses it iteratively as a carry-save accumulator. Each iteration compresses the running sum, the running carry and two Booth partial products into a new sum/carry pair. A final carry-propagate add produces the product, and a start/busy/done handshake exposes the result to the ALU/control unit.

## Interface
Parameters:
- none; widths are fixed at 32-bit operands and a 64-bit product.

Ports:
- in_clk  input  1  system clock; all state updates on the rising edge.
- in_rst_n  input  1  asynchronous, active-low reset.
- in_start  input  1  request; sampled only in IDLE.
- in_multiplicand  input  32  M; two's complement.
- in_multiplier  input  32  Q; two's complement.
- out_busy  output  1  high while an operation is in progress.
- out_done  output  1  one-cycle pulse; out_product is valid on the same cycle.
- out_product  output  64  result; held until the next accepted start.

## Operation
- FSM states: IDLE, ITER, ADD.
- **IDLE**
  - in_start=1 latches M (sign-extended to 64 bits) and Q.
  - Q is held in a 33-bit shift register as {Q, 1'b0}.
  - Clears sum_r and carry_r to 0 and clears iteration counter k to 0.
  - Next state is ITER.
- **ITER** (k = 0..7)
  - Window bits [4:0] of the Q shift register give two Booth digits:
    - d0 from bits {2,1,0}.
    - d1 from bits {4,3,2}.
    - Each digit is in {-2,-1,0,+1,+2}.
  - Partial products, each truncated to 64 bits:
    - pp0 = d0*M << 4k.
    - pp1 = d1*M << (4k+2).
  - -M and -2M are full two's complement values.
  - Reducer inputs: in_w=sum_r, in_x=carry_r, in_y=pp0, in_z=pp1, in_cin=0.
  - Register out_sum into sum_r and out_carry into carry_r. out_carry is already shifted left by 1.
  - out_cout is discarded; all arithmetic is mod 2^64.
  - Shift Q right by 4 with sign fill, then k++.
  - After k=7, next state is ADD.
- **ADD**
  - out_product <= sum_r + carry_r (64-bit, mod 2^64).
  - out_done <= 1 for this cycle only.
  - Next state is IDLE.
- in_start while out_busy=1 is ignored. It is not queued.
- Operand inputs are don't-care except in the cycle in_start is accepted.

## Timing
- Reset values: out_busy=0, out_done=0, out_product=0, state=IDLE, k=0, sum_r=0, carry_r=0.
- Reset is asynchronous: asserting in_rst_n mid-operation aborts immediately. No done pulse follows, and the next start behaves as after power-up.
- Start accepted at edge E0: ITER spans edges E1..E8, ADD registers at E9.
- out_done=1 and the new out_product are visible after E9; latency is 9 cycles.
- out_busy=1 after E0 through E8; it falls at E9, the same edge that out_done rises.
- Back-to-back: in_start high in the out_done cycle is accepted, because the state is IDLE. The next result follows 9 cycles later.
- Throughput is one product per 9 cycles. out_product is unchanged between done pulses.

## Configuration
- **BOOTH_UNSIGNED_EN defined**
  - Adds port in_unsigned (input, 1), sampled with in_start.
  - When 1: M is zero-extended to 64 bits, and Q is zero-extended to 36 bits plus the appended 0.
  - A 9th ITER (k=8) consumes the top digits; latency is 10 cycles and out_busy covers E0..E9.
  - When 0: behaviour is identical to signed mode, latency 9.
- **Undefined**
  - No in_unsigned port; signed operation only.
  - The k=8 path is not synthesized.

## Test plan
- Small signed operands: M=6, Q=7, start -> out_done exactly 9 cycles later with out_product=0x000000000000002A; out_busy low on the done cycle.
- Mixed and negative signs:
  - M=-5, Q=3 -> 0xFFFFFFFFFFFFFFF1.
  - M=0xFFFFFFFF, Q=0xFFFFFFFF -> 0x0000000000000001.
- Extremes: M=Q=0x80000000 -> 0x4000000000000000; M=0x7FFFFFFF, Q=0x80000000 -> 0xC000000080000000.
- Handshake:
  - A second start (M=2, Q=2) pulsed at cycle 4 of 6*7 is ignored; the result is 42 and no second done occurs.
  - A start in the done cycle with M=3, Q=4 yields 12 nine cycles later.
- Reset mid-operation: in_rst_n low at cycle 5 -> all outputs 0 immediately and no done pulse; a subsequent 6*7 returns 42.
- With BOOTH_UNSIGNED_EN:
  - in_unsigned=1, M=Q=0xFFFFFFFF -> 0xFFFFFFFE00000001 after 10 cycles.
  - in_unsigned=0 with the same operands -> 1 after 9 cycles.
